// File: rtl/aes_pkg.sv
// Shared AES-128 types and constants: block/word types, key-schedule FSM states,
// forward S-box, round constants and the round-constant lookup helper.
package aes_pkg;

   typedef logic [31:0]  aes_word_t;
   typedef logic [127:0] aes_block_t;

   typedef enum logic [1:0] {
      KS_IDLE   = 2'd0,
      KS_EXPAND = 2'd1,
      KS_DONE   = 2'd2
   } ks_state_t;

   localparam int N_ROUNDS = 10;

   localparam logic [7:0] SBOX [0:255] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   localparam logic [7:0] RCON [1:10] = '{
      8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
   };

   // Round constant for round 1..10; any other index yields zero.
   function automatic logic [7:0] rcon_of(input logic [3:0] rnd);
      logic [7:0] v;
      v = 8'h00;
      for (int i = 1; i <= N_ROUNDS; i++) begin
         v = v | ({8{rnd == 4'(i)}} & RCON[i]);
      end
      return v;
   endfunction

endpackage

// File: rtl/aes_key_schedule_sub_word.sv
// SubWord: forward S-box applied to each byte of a 32-bit word (pure combinational).
module sub_word (
   input  logic [31:0] word_i,
   output logic [31:0] word_o
);
   import aes_pkg::*;

   // Four independent byte substitutions.
   always_comb begin
      word_o = {SBOX[word_i[31:24]], SBOX[word_i[23:16]],
                SBOX[word_i[15:8]],  SBOX[word_i[7:0]]};
   end

endmodule

// File: rtl/aes_key_schedule.sv
// Iterative AES-128 key expansion: one round key per clock into an 11-entry
// register file, with a registered random-access read port for the decrypt core.
module aes_key_schedule (
   input  logic         CLK,
   input  logic         RESET,
   input  logic         KS_START,
   input  logic [127:0] KS_KEY,
   output logic         KS_BUSY,
   output logic         KS_DONE,
   input  logic [3:0]   KS_RD_ROUND,
   output logic [127:0] KS_RD_KEY
);
   // Imported after the ports: the KS_DONE port name shadows the enum literal,
   // so FSM states are always referenced with the package prefix.
   import aes_pkg::*;

   localparam logic [3:0] LAST_RND = 4'(N_ROUNDS);

   ks_state_t  state_q, state_d;
   logic [3:0] rnd_q, rnd_d;
   aes_block_t rk_q [0:10];
   aes_block_t rk_d [0:10];
   aes_block_t rd_key_q, rd_key_d;

   aes_block_t prev_key_s, next_key_s, wr_data_s;
   aes_word_t  rot_s, sub_s, t_s, n0_s, n1_s, n2_s, n3_s;
   logic       wr_en_s;
   logic [3:0] wr_idx_s;

   // Select rk[r-1] as the source of the round being generated.
   always_comb begin
      prev_key_s = {128{1'b0}};
      for (int i = 0; i < N_ROUNDS; i++) begin
         prev_key_s = prev_key_s | ({128{rnd_q == 4'(i + 1)}} & rk_q[i]);
      end
   end

   assign rot_s = {prev_key_s[23:0], prev_key_s[31:24]};

   sub_word u_sub_word (
      .word_i (rot_s),
      .word_o (sub_s)
   );

   // One round of the key schedule: S-box then a 4-deep XOR chain.
   always_comb begin
      t_s        = sub_s ^ {rcon_of(rnd_q), 24'h000000};
      n0_s       = prev_key_s[127:96] ^ t_s;
      n1_s       = prev_key_s[95:64]  ^ n0_s;
      n2_s       = prev_key_s[63:32]  ^ n1_s;
      n3_s       = prev_key_s[31:0]   ^ n2_s;
      next_key_s = {n0_s, n1_s, n2_s, n3_s};
   end

   // FSM next-state, round counter and register-file write request.
   always_comb begin
      state_d   = state_q;
      rnd_d     = rnd_q;
      wr_en_s   = 1'b0;
      wr_idx_s  = 4'd0;
      wr_data_s = next_key_s;
      case (state_q)
         aes_pkg::KS_IDLE: begin
            if (KS_START) begin
               state_d   = aes_pkg::KS_EXPAND;
               rnd_d     = 4'd1;
               wr_en_s   = 1'b1;
               wr_data_s = KS_KEY;
            end else begin
               state_d = aes_pkg::KS_IDLE;
            end
         end
         aes_pkg::KS_EXPAND: begin
            wr_en_s  = 1'b1;
            wr_idx_s = rnd_q;
            rnd_d    = rnd_q + 4'd1;
            if (rnd_q == LAST_RND) begin
               state_d = aes_pkg::KS_DONE;
            end else begin
               state_d = aes_pkg::KS_EXPAND;
            end
         end
         aes_pkg::KS_DONE: begin
            if (!KS_START) begin
               state_d = aes_pkg::KS_IDLE;
            end else begin
               state_d = aes_pkg::KS_DONE;
            end
         end
         default: begin
            state_d = aes_pkg::KS_IDLE;
            rnd_d   = 4'd0;
         end
      endcase
   end

   // Single write port into the round-key register file.
   always_comb begin
      for (int i = 0; i <= N_ROUNDS; i++) begin
         if (wr_en_s && (wr_idx_s == 4'(i))) begin
            rk_d[i] = wr_data_s;
         end else begin
            rk_d[i] = rk_q[i];
         end
      end
   end

   // Read mux; indices beyond round 10 read as zero.
   always_comb begin
      rd_key_d = {128{1'b0}};
      for (int i = 0; i <= N_ROUNDS; i++) begin
         rd_key_d = rd_key_d | ({128{KS_RD_ROUND == 4'(i)}} & rk_q[i]);
      end
   end

   // FSM state and round counter registers.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q <= aes_pkg::KS_IDLE;
         rnd_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         rnd_q   <= rnd_d;
      end
   end

   // Round-key storage and registered read data.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         for (int i = 0; i <= N_ROUNDS; i++) begin
            rk_q[i] <= {128{1'b0}};
         end
         rd_key_q <= {128{1'b0}};
      end else begin
         for (int i = 0; i <= N_ROUNDS; i++) begin
            rk_q[i] <= rk_d[i];
         end
         rd_key_q <= rd_key_d;
      end
   end

   assign KS_BUSY   = (state_q == aes_pkg::KS_EXPAND);
   assign KS_DONE   = (state_q == aes_pkg::KS_DONE);
   assign KS_RD_KEY = rd_key_q;

endmodule

// File: tb/tb_aes_key_schedule.sv
// Self-checking bench for aes_key_schedule: directed handshake/timing steps plus
// random keys, checked against a FIPS-197 style key expansion built from GF(2^8).
module tb_aes_key_schedule;

   logic         CLK;
   logic         RESET;
   logic         KS_START;
   logic [127:0] KS_KEY;
   logic         KS_BUSY;
   logic         KS_DONE;
   logic [3:0]   KS_RD_ROUND;
   logic [127:0] KS_RD_KEY;

   int total;
   int bad;

   localparam logic [127:0] KEY_A = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;

   aes_key_schedule dut (
      .CLK         (CLK),
      .RESET       (RESET),
      .KS_START    (KS_START),
      .KS_KEY      (KS_KEY),
      .KS_BUSY     (KS_BUSY),
      .KS_DONE     (KS_DONE),
      .KS_RD_ROUND (KS_RD_ROUND),
      .KS_RD_KEY   (KS_RD_KEY)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
   function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
      logic [7:0] a, b, p;
      a = a_in; b = b_in; p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
         b = b >> 1;
      end
      return p;
   endfunction

   // S-box from first principles: multiplicative inverse then affine map.
   function automatic logic [7:0] ref_sbox(input logic [7:0] x);
      logic [7:0] inv, s;
      inv = 8'h01;
      for (int i = 0; i < 254; i++) inv = gmul(inv, x);
      if (x == 8'h00) inv = 8'h00;
      s = inv;
      for (int k = 1; k <= 4; k++) s = s ^ ((inv << k) | (inv >> (8 - k)));
      return s ^ 8'h63;
   endfunction

   // Round key r of the standard 44-word expansion; indices above 10 read as zero.
   function automatic logic [127:0] ref_round(input logic [127:0] key, input int r);
      logic [31:0] w [0:43];
      logic [31:0] tmp;
      logic [7:0]  rc;
      if (r > 10) return 128'h0;
      for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
      rc = 8'h01;
      for (int i = 4; i < 44; i++) begin
         tmp = w[i-1];
         if (i % 4 == 0) begin
            tmp = {ref_sbox(tmp[23:16]), ref_sbox(tmp[15:8]), ref_sbox(tmp[7:0]), ref_sbox(tmp[31:24])}
                  ^ {rc, 24'h000000};
            rc = gmul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ tmp;
      end
      return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic rd_check(input string tag, input int r, input logic [127:0] exp);
      KS_RD_ROUND = 4'(r);
      @(posedge CLK); #1;
      chk(tag, KS_RD_KEY, exp);
   endtask

   // Start an expansion from the current (IDLE) state and check the 10-cycle timing.
   // If drop_at >= 0, KS_START is dropped and KS_KEY scrambled right after edge E<drop_at>.
   task automatic expand(input logic [127:0] key, input int drop_at);
      KS_START = 1'b1;
      KS_KEY   = key;
      for (int e = 0; e < 10; e++) begin
         @(posedge CLK); #1;
         if (e == drop_at) begin
            KS_START = 1'b0;
            KS_KEY   = {$urandom, $urandom, $urandom, $urandom};
         end
         chk($sformatf("busy_E%0d", e), {127'h0, KS_BUSY}, 128'h1);
         chk($sformatf("done_E%0d", e), {127'h0, KS_DONE}, 128'h0);
      end
      @(posedge CLK); #1;
      chk("done_E10", {127'h0, KS_DONE}, 128'h1);
      chk("busy_E10", {127'h0, KS_BUSY}, 128'h0);
   endtask

   task automatic drop_start();
      KS_START = 1'b0;
      @(posedge CLK); #1;
      chk("idle_done", {127'h0, KS_DONE}, 128'h0);
      chk("idle_busy", {127'h0, KS_BUSY}, 128'h0);
   endtask

   initial begin
      logic [127:0] rkey;
      total       = 0;
      bad         = 0;
      RESET       = 1'b1;
      KS_START    = 1'b1;
      KS_KEY      = KEY_A;
      KS_RD_ROUND = 4'd0;

      // Reset held with KS_START high: outputs stay zero.
      repeat (3) @(posedge CLK);
      #1;
      chk("rst_busy", {127'h0, KS_BUSY}, 128'h0);
      chk("rst_done", {127'h0, KS_DONE}, 128'h0);
      chk("rst_rdkey", KS_RD_KEY, 128'h0);
      @(negedge CLK);
      RESET = 1'b0;
      expand(KEY_A, -1);

      // Round 10 requested in the first DONE cycle, then the known vectors.
      rd_check("A_r10_first", 10, ref_round(KEY_A, 10));
      rd_check("A_r0_vec", 0, 128'h000102030405060708090a0b0c0d0e0f);
      rd_check("A_r1_vec", 1, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
      rd_check("A_r10_vec", 10, 128'h13111d7fe3944a17f307a78b4d2b30c5);
      chk("A_still_done", {127'h0, KS_DONE}, 128'h1);

      // Back-to-back: one low cycle, then the second key.
      drop_start();
      rd_check("A_r5_idle", 5, ref_round(KEY_A, 5));
      expand(KEY_B, -1);
      rd_check("B_r1_vec", 1, 128'ha0fafe1788542cb123a339392a6c7605);
      rd_check("B_r10_vec", 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      rd_check("B_r11", 11, 128'h0);
      rd_check("B_r15", 15, 128'h0);
      for (int r = 0; r <= 15; r++) rd_check($sformatf("B_all_r%0d", r), r, ref_round(KEY_B, r));
      drop_start();

      // Perturbed run: KS_KEY changed and KS_START dropped after E3.
      expand(KEY_A, 3);
      rd_check("pert_r10_first", 10, ref_round(KEY_A, 10));
      chk("pert_done_1cyc", {127'h0, KS_DONE}, 128'h0);
      chk("pert_busy_idle", {127'h0, KS_BUSY}, 128'h0);
      for (int r = 0; r <= 10; r++) rd_check($sformatf("pert_r%0d", r), r, ref_round(KEY_A, r));

      // Asynchronous reset after E5 of an expansion.
      rkey        = {$urandom, $urandom, $urandom, $urandom};
      KS_START    = 1'b1;
      KS_KEY      = rkey;
      KS_RD_ROUND = 4'd0;
      repeat (6) @(posedge CLK);
      #2;
      chk("mid_busy_pre", {127'h0, KS_BUSY}, 128'h1);
      chk("mid_rd_pre", KS_RD_KEY, rkey);
      RESET = 1'b1;
      #1;
      chk("mid_rst_busy", {127'h0, KS_BUSY}, 128'h0);
      chk("mid_rst_done", {127'h0, KS_DONE}, 128'h0);
      chk("mid_rst_rdkey", KS_RD_KEY, 128'h0);
      KS_START = 1'b0;
      @(negedge CLK);
      RESET = 1'b0;
      #1;
      rd_check("mid_cleared_r0", 0, 128'h0);
      rd_check("mid_cleared_r4", 4, 128'h0);
      chk("mid_stays_idle", {127'h0, KS_BUSY}, 128'h0);
      expand(KEY_B, -1);
      rd_check("mid_B_r10", 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      drop_start();

      // Random keys with full readback.
      for (int n = 0; n < 3; n++) begin
         rkey = {$urandom, $urandom, $urandom, $urandom};
         expand(rkey, -1);
         for (int r = 0; r <= 15; r++) rd_check($sformatf("rnd%0d_r%0d", n, r), r, ref_round(rkey, r));
         drop_start();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
